ras_ckpt: RTL

RAS_CKPT -- requirements
Module: ras_ckpt

---
 rtl/ras_ckpt.sv | 117 +++++++++++
 1 files changed

// File: rtl/ras_ckpt.sv
// Return-address stack: speculative copy restored from a committed copy; define RAS_RECUR_EN for per-entry recursion counters.
// Latency: PredPop result appears on TopValid/TopAddr one cycle later; Recover restores the speculative stack in one cycle.
// Backpressure: none; Stall freezes speculative state and outputs, Recover overrides Stall.
module ras_ckpt #(
  parameter int DEPTH = 16,
  parameter int PTRW  = 4,
  parameter int ADDRW = 32,
  parameter int CNTW  = 3
) (
  input  logic             Clk,
  input  logic             Rest,
  input  logic             Stall,
  input  logic             PredPush,
  input  logic             PredPop,
  input  logic [ADDRW-1:0] PredAddr,
  input  logic             CmtPush,
  input  logic             CmtPop,
  input  logic [ADDRW-1:0] CmtAddr,
  input  logic             Recover,
  output logic             TopValid,
  output logic [ADDRW-1:0] TopAddr,
  output logic [PTRW:0]    SpecCount
);

  localparam logic [PTRW:0] FULL = (PTRW+1)'(DEPTH);
`ifdef RAS_RECUR_EN
  localparam logic [CNTW-1:0] CNT_MAX = '1;
`endif

  // Whole stack as one packed word so a checkpoint copy is a single assignment.
  typedef struct packed {
    logic [PTRW-1:0]        ptr;
    logic [PTRW:0]          occ;
    logic [DEPTH*ADDRW-1:0] addr;
`ifdef RAS_RECUR_EN
    logic [DEPTH*CNTW-1:0]  cnt;
`endif
  } stk_t;

  // ptr names the next free slot; the top entry lives at ptr-1 (mod DEPTH).
  function automatic stk_t stackStep(input stk_t s, input logic push, input logic pop,
                                     input logic [ADDRW-1:0] a);
    stk_t            n;
    logic [PTRW-1:0] top;
    logic            alloc;
    n     = s;
    top   = s.ptr - 1'b1;
    alloc = push;
    if (pop && s.occ != '0) begin
`ifdef RAS_RECUR_EN
      if (s.cnt[top*CNTW +: CNTW] != '0) begin
        n.cnt[top*CNTW +: CNTW] = s.cnt[top*CNTW +: CNTW] - 1'b1;
      end else begin
        n.ptr = top;
        n.occ = s.occ - 1'b1;
      end
`else
      n.ptr = top;
      n.occ = s.occ - 1'b1;
`endif
    end
    // Push acts on the post-pop stack, so a same-cycle pop+push replaces the top.
    top = n.ptr - 1'b1;
`ifdef RAS_RECUR_EN
    if (push && n.occ != '0 && n.addr[top*ADDRW +: ADDRW] == a &&
        n.cnt[top*CNTW +: CNTW] != CNT_MAX) begin
      n.cnt[top*CNTW +: CNTW] = n.cnt[top*CNTW +: CNTW] + 1'b1;
      alloc = 1'b0;
    end
`endif
    if (alloc) begin
      n.addr[n.ptr*ADDRW +: ADDRW] = a;
`ifdef RAS_RECUR_EN
      n.cnt[n.ptr*CNTW +: CNTW] = '0;
`endif
      n.ptr = n.ptr + 1'b1;
      if (n.occ != FULL) n.occ = n.occ + 1'b1;
    end
    return n;
  endfunction

  stk_t            spec, cmt, specNxt, cmtNxt;
  logic [PTRW-1:0] topIdx;
  logic [ADDRW-1:0] specTop;
  logic            popHit;

  always_comb begin
    specNxt = stackStep(spec, PredPush, PredPop, PredAddr);
    cmtNxt  = stackStep(cmt, CmtPush, CmtPop, CmtAddr);
    topIdx  = spec.ptr - 1'b1;
    specTop = spec.addr[topIdx*ADDRW +: ADDRW];
    popHit  = PredPop && (spec.occ != '0);
  end

  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      spec     <= '0;
      cmt      <= '0;
      TopValid <= 1'b0;
      TopAddr  <= '0;
    end else begin
      cmt <= cmtNxt;
      // Recover takes the committed stack including this cycle's retire update.
      if (Recover) begin
        spec     <= cmtNxt;
        TopValid <= 1'b0;
      end else if (!Stall) begin
        spec     <= specNxt;
        TopValid <= popHit;
        if (popHit) TopAddr <= specTop;
      end
    end
  end

  assign SpecCount = spec.occ;

endmodule
